// File: rtl/sprite_pkg.sv
//------------------------------------------------------------------------------
// Module   : sprite_pkg
// Brief    : Field layout, packed word types and constants for sprite_addr_cal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sprite_pkg;

    // pattern_info bit offsets (each field is 16 bits wide)
    localparam int c_PI_BASE_LSB   = 64;
    localparam int c_PI_TILE_W_LSB = 48;
    localparam int c_PI_TILE_H_LSB = 32;
    localparam int c_PI_WIN_W_LSB  = 16;
    localparam int c_PI_WIN_H_LSB  = 0;

    // sprite_info bit offsets
    localparam int c_SI_VISIBLE_BIT = 31;
    localparam int c_SI_FLIP_BIT    = 30;
    localparam int c_SI_X_LSB       = 20;
    localparam int c_SI_Y_LSB       = 10;
    localparam int c_SI_SHIFT_LSB   = 0;

    localparam logic [15:0] ADDR_INVALID = 16'h0000;

    typedef struct packed {
        logic [15:0] base;
        logic [15:0] tile_w;
        logic [15:0] tile_h;
        logic [15:0] win_w;
        logic [15:0] win_h;
    } pattern_info_t;

    typedef struct packed {
        logic       visible;
        logic       flip;
        logic [9:0] x_org;
        logic [9:0] y_org;
        logic [9:0] shift;
    } sprite_info_t;

endpackage : sprite_pkg

`default_nettype wire

// File: rtl/sprite_addr_cal.sv
//------------------------------------------------------------------------------
// Module   : sprite_addr_cal
// Brief    : Per-pixel sprite window test and pattern-memory address, 1-clk
//            registered. Define SPRITE_ADDR_CAL_FLIP_EN to enable mirroring.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_addr_cal
    import sprite_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [79:0]        pattern_info,
    input  logic [31:0]        sprite_info,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    output logic [ADDR_W-1:0]  addr_output,
    output logic               valid
);

    localparam int c_DW = COORD_W + 1;

    pattern_info_t   w_pat;
    sprite_info_t    w_spr;
    logic [c_DW-1:0] w_dx;
    logic [c_DW-1:0] w_dy;
    logic [c_DW-1:0] w_hsum;
    logic [15:0]     w_col_mask;
    logic [15:0]     w_row_mask;
    logic [15:0]     w_col;
    logic [15:0]     w_col_eff;
    logic [15:0]     w_row;
    logic [15:0]     w_addr;
    logic            w_inside;

    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;

    assign w_pat = pattern_info_t'(pattern_info);
    assign w_spr = sprite_info_t'(sprite_info);

    always_comb begin
        // One extra bit makes the differences two's-complement; the MSB is the sign.
        w_dx       = {1'b0, hcount} - {1'b0, COORD_W'(w_spr.x_org)};
        w_dy       = {1'b0, vcount} - {1'b0, COORD_W'(w_spr.y_org)};
        w_inside   = w_spr.visible
                   && !w_dx[c_DW-1] && (16'(w_dx) < w_pat.win_w)
                   && !w_dy[c_DW-1] && (16'(w_dy) < w_pat.win_h);

        w_col_mask = w_pat.tile_w - 16'd1;
        w_row_mask = w_pat.tile_h - 16'd1;
        w_hsum     = w_dx + c_DW'(w_spr.shift);
        w_col      = 16'(w_hsum) & w_col_mask;
        w_row      = 16'(w_dy) & w_row_mask;

`ifdef SPRITE_ADDR_CAL_FLIP_EN
        w_col_eff  = w_spr.flip ? (w_col_mask - w_col) : w_col;
`else
        // Flip bit is deliberately ignored in this build.
        w_col_eff  = w_col | {16{w_spr.flip & 1'b0}};
`endif

        w_addr     = w_pat.base + (w_row * w_pat.tile_w) + w_col_eff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= ADDR_W'(ADDR_INVALID);
        end else begin
            r_valid <= w_inside;
            r_addr  <= w_inside ? ADDR_W'(w_addr) : ADDR_W'(ADDR_INVALID);
        end
    end

    assign valid       = r_valid;
    assign addr_output = r_addr;

endmodule : sprite_addr_cal

`default_nettype wire

// File: tb/tb_sprite_addr_cal.sv
//------------------------------------------------------------------------------
// Module   : tb_sprite_addr_cal
// Brief    : Directed and randomized self-checking bench for sprite_addr_cal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sprite_addr_cal;
    import sprite_pkg::*;

`ifdef SPRITE_ADDR_CAL_FLIP_EN
    localparam bit c_FLIP_EN = 1'b1;
`else
    localparam bit c_FLIP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    pattern_info_t pat;
    sprite_info_t  spr;
    logic [9:0]    hcount;
    logic [9:0]    vcount;
    logic [15:0]   addr_output;
    logic          valid;

    int compared   = 0;
    int mismatched = 0;

    sprite_addr_cal #(.ADDR_W(16), .COORD_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pat),
        .sprite_info  (spr),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic straight from the pixel rules.
    function automatic void ref_model(output bit exp_v, output int exp_a);
        int dx, dy, tw, th, col, row;
        dx = int'(hcount) - int'(spr.x_org);
        dy = int'(vcount) - int'(spr.y_org);
        tw = int'(pat.tile_w);
        th = int'(pat.tile_h);
        exp_v = spr.visible && dx >= 0 && dx < int'(pat.win_w)
                && dy >= 0 && dy < int'(pat.win_h);
        if (!exp_v) begin
            exp_a = 0;
            return;
        end
        col = ((dx + int'(spr.shift)) % 2048) % tw;
        if (c_FLIP_EN && spr.flip) col = tw - 1 - col;
        row = dy % th;
        exp_a = (int'(pat.base) + row * tw + col) % 65536;
    endfunction

    task automatic compare(input string tag, input bit exp_v, input int exp_a);
        compared++;
        assert (valid === exp_v) else begin
            mismatched++;
            $error("FAIL %s valid: observed %0b expected %0b", tag, valid, exp_v);
        end
        compared++;
        assert (addr_output === 16'(exp_a)) else begin
            mismatched++;
            $error("FAIL %s addr: observed %0d expected %0d", tag, addr_output, exp_a);
        end
    endtask

    // Inputs are already applied; check one clk later.
    task automatic step(input string tag, input bit exp_v, input int exp_a);
        @(posedge clk); #1;
        compare(tag, exp_v, exp_a);
    endtask

    task automatic step_valid(input string tag, input bit exp_v);
        @(posedge clk); #1;
        compared++;
        assert (valid === exp_v) else begin
            mismatched++;
            $error("FAIL %s valid: observed %0b expected %0b", tag, valid, exp_v);
        end
    endtask

    task automatic set_ground();
        pat = '{base: 16'd0, tile_w: 16'd16, tile_h: 16'd16, win_w: 16'd650, win_h: 16'd32};
        spr = '{visible: 1'b1, flip: 1'b0, x_org: 10'd0, y_org: 10'd368, shift: 10'd0};
    endtask

    initial begin
        bit exp_v;
        int exp_a;

        reset  = 1'b1;
        hcount = 10'd5;
        vcount = 10'd370;
        set_ground();
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", 1'b0, 0);
        reset = 1'b0;

        step("pix_a", 1'b1, 37);
        hcount = 10'd20; vcount = 10'd385;
        step("pix_b", 1'b1, 20);

        vcount = 10'd367;
        step("above_win", 1'b0, 0);
        vcount = 10'd399;
        step_valid("last_row", 1'b1);
        vcount = 10'd400;
        step("below_win", 1'b0, 0);

        spr.x_org = 10'd100; hcount = 10'd99; vcount = 10'd370;
        step("left_of_x", 1'b0, 0);
        spr.x_org = 10'd0; pat.win_w = 16'd650; hcount = 10'd639;
        step("right_col", 1'b1, 47);
        spr.visible = 1'b0;
        step("invisible", 1'b0, 0);
        spr.visible = 1'b1;

        spr.shift = 10'd3; hcount = 10'd14; vcount = 10'd368;
        step("scroll_3", 1'b1, 1);
        spr.shift = 10'd1023; hcount = 10'd0;
        step("scroll_wrap", 1'b1, 15);

        spr.shift = 10'd0; spr.flip = 1'b1; hcount = 10'd5; vcount = 10'd370;
        step("flip", 1'b1, c_FLIP_EN ? 42 : 37);
        spr.flip = 1'b0;

        pat.win_w = 16'd0;
        step("zero_win_w", 1'b0, 0);
        pat.win_w = 16'd650; pat.win_h = 16'd0;
        step("zero_win_h", 1'b0, 0);
        pat.win_h = 16'd32;

        step("pre_reset", 1'b1, 37);
        reset = 1'b1;
        #1;
        compare("async_reset", 1'b0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        pat.base = 16'd128;
        step("base_128", 1'b1, 165);

        // Random descriptors and beam positions against the reference model.
        for (int i = 0; i < 300; i++) begin
            pat.base    = 16'($urandom);
            pat.tile_w  = 16'(1 << $urandom_range(0, 10));
            pat.tile_h  = 16'(1 << $urandom_range(0, 10));
            pat.win_w   = 16'($urandom_range(0, 1100));
            pat.win_h   = 16'($urandom_range(0, 600));
            spr.visible = ($urandom_range(0, 7) != 0);
            spr.flip    = 1'($urandom);
            spr.x_org   = 10'($urandom);
            spr.y_org   = 10'($urandom);
            spr.shift   = 10'($urandom);
            hcount      = 10'($urandom);
            vcount      = 10'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                hcount = spr.x_org + 10'($urandom_range(0, 63));
                vcount = spr.y_org + 10'($urandom_range(0, 63));
            end
            ref_model(exp_v, exp_a);
            step("random", exp_v, exp_a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_sprite_addr_cal

`default_nettype wire
